// File: rtl/sram_arbiter.sv
// ============================================================================
// Module     : sram_arbiter
// Description: Fixed-priority arbiter sharing one async 32-bit SRAM between
//              an instruction-fetch port and a data port, with multi-cycle
//              read wait and write setup / WE pulse / hold timing.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int READ_WAIT = 1,
    parameter int WE_PULSE  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_sel,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ack,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_data_i,
    output logic [31:0]       ram_data_o,
    output logic              ram_data_oe,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [3:0]        ram_be_n,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [3:0] c_READ_LAST  = 4'(READ_WAIT);
    localparam logic [3:0] c_PULSE_LAST = 4'(WE_PULSE - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_gnt_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_gnt_mem   <= 1'b0;
            if_rdata    <= 32'd0;
            if_ack      <= 1'b0;
            mem_rdata   <= 32'd0;
            mem_ack     <= 1'b0;
            ram_addr    <= '0;
            ram_data_o  <= 32'd0;
            ram_data_oe <= 1'b0;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_be_n    <= 4'hF;
            busy        <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_req || if_req) begin
                        // Data port wins ties; the fetch port retries at the next IDLE.
                        r_gnt_mem <= mem_req;
                        ram_addr  <= mem_req ? mem_addr : if_addr;
                        busy      <= 1'b1;
                        ram_ce_n  <= 1'b0;
                        if (mem_req && mem_we) begin
                            r_state     <= S_WR_SETUP;
                            r_cnt       <= c_PULSE_LAST;
                            ram_oe_n    <= 1'b1;
                            ram_we_n    <= 1'b1;
                            ram_be_n    <= ~mem_sel;
                            ram_data_o  <= mem_wdata;
                            ram_data_oe <= 1'b1;
                        end else begin
                            r_state     <= S_READ;
                            r_cnt       <= c_READ_LAST;
                            ram_oe_n    <= 1'b0;
                            ram_be_n    <= 4'h0;
                            ram_data_oe <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    if (r_cnt == 4'd0) begin
                        if (r_gnt_mem) begin
                            mem_rdata <= ram_data_i;
                            mem_ack   <= 1'b1;
                        end else begin
                            if_rdata <= ram_data_i;
                            if_ack   <= 1'b1;
                        end
                        ram_ce_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        ram_be_n <= 4'hF;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WR_SETUP: begin
                    ram_we_n <= 1'b0;
                    r_state  <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (r_cnt == 4'd0) begin
                        ram_we_n <= 1'b1;
                        r_state  <= S_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WR_HOLD: begin
                    // Writes only ever come from the data port.
                    ram_ce_n    <= 1'b1;
                    ram_be_n    <= 4'hF;
                    ram_data_oe <= 1'b0;
                    mem_ack     <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module     : tb_sram_arbiter
// Description: Self-checking bench for sram_arbiter; three instances with
//              different timing parameters, each with its own SRAM model.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    always #5 clk = ~clk;

    logic        if_req[3], mem_req[3], mem_we[3];
    logic [19:0] if_addr[3], mem_addr[3], ram_addr[3];
    logic [3:0]  mem_sel[3], ram_be_n[3];
    logic [31:0] mem_wdata[3], if_rdata[3], mem_rdata[3], ram_data_i[3], ram_data_o[3];
    logic        if_ack[3], mem_ack[3], ram_data_oe[3], ram_ce_n[3], ram_oe_n[3], ram_we_n[3], busy[3];
    logic [31:0] sram[3][256];
    logic [31:0] ref_mem[3][256];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int rw_of(int g);
        return (g == 0) ? 1 : (g == 1) ? 0 : 3;
    endfunction

    function automatic int wp_of(int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 4;
    endfunction

    function automatic logic [31:0] pat(int g, int a);
        if (a == 16) return 32'h24020001;
        return ((32'(a) + 32'd1) * 32'h9E3779B1) ^ (32'(g) << 28);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_arbiter #(.ADDR_W(20), .READ_WAIT(rw_of(g)), .WE_PULSE(wp_of(g))) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ack(if_ack[g]),
            .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_sel(mem_sel[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .mem_ack(mem_ack[g]),
            .ram_addr(ram_addr[g]), .ram_data_i(ram_data_i[g]), .ram_data_o(ram_data_o[g]),
            .ram_data_oe(ram_data_oe[g]), .ram_ce_n(ram_ce_n[g]), .ram_oe_n(ram_oe_n[g]),
            .ram_we_n(ram_we_n[g]), .ram_be_n(ram_be_n[g]), .busy(busy[g])
        );
        assign ram_data_i[g] = (!ram_ce_n[g] && !ram_oe_n[g]) ? sram[g][ram_addr[g][7:0]] : 32'hDEADBEEF;
    end

    // Async SRAM model: byte lanes written on every clock while CE and WE are low.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int g = 0; g < 3; g++)
                for (int a = 0; a < 256; a++) sram[g][a] <= pat(g, a);
        end else begin
            for (int g = 0; g < 3; g++)
                if (!ram_ce_n[g] && !ram_we_n[g])
                    for (int b = 0; b < 4; b++)
                        if (!ram_be_n[g][b]) sram[g][ram_addr[g][7:0]][8*b +: 8] <= ram_data_o[g][8*b +: 8];
        end
    end

    // Issues one request on one instance and reports what the bus did; lat is
    // the cycle offset of the ack from the cycle the request was first seen.
    task automatic run_txn(input int g, input bit is_mem, input bit we, input logic [19:0] addr,
                           input logic [3:0] sel, input logic [31:0] wd, output int lat,
                           output logic [31:0] rd, output int we_first, output int we_cnt, output int viol);
        lat = -1; rd = '0; we_first = -1; we_cnt = 0; viol = 0;
        @(negedge clk);
        if (is_mem) begin
            mem_req[g] = 1'b1; mem_we[g] = we; mem_addr[g] = addr; mem_sel[g] = sel; mem_wdata[g] = wd;
        end else begin
            if_req[g] = 1'b1; if_addr[g] = addr;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ram_data_oe[g] && !ram_oe_n[g]) viol++;
            if (!busy[g] || ram_addr[g] !== addr) viol++;
            if (!ram_we_n[g]) begin
                if (we_first < 0) we_first = k;
                we_cnt++;
                if (ram_ce_n[g] || !ram_data_oe[g] || ram_be_n[g] !== ~sel) viol++;
            end
            if (is_mem ? if_ack[g] : mem_ack[g]) viol++;
            if (is_mem ? mem_ack[g] : if_ack[g]) begin
                lat = k;
                rd  = is_mem ? mem_rdata[g] : if_rdata[g];
                break;
            end
        end
        mem_req[g] = 1'b0;
        if_req[g]  = 1'b0;
    endtask

    task automatic test_reset();
        for (int g = 0; g < 3; g++) begin
            if_req[g] = 0; mem_req[g] = 0; mem_we[g] = 0; if_addr[g] = '0;
            mem_addr[g] = '0; mem_sel[g] = '0; mem_wdata[g] = '0;
            for (int a = 0; a < 256; a++) ref_mem[g][a] = pat(g, a);
        end
        rst = 1'b1; mem_init = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if ({ram_ce_n[g], ram_oe_n[g], ram_we_n[g], ram_be_n[g], ram_data_oe[g], if_ack[g], mem_ack[g], busy[g]}
                !== 11'b111_1111_0000 || if_rdata[g] !== 32'd0 || mem_rdata[g] !== 32'd0 || ram_addr[g] !== 20'd0) begin
                n_fail++;
                $display("FAIL reset inst%0d: ce%b oe%b we%b be%h doe%b ack%b%b busy%b addr%h, required 1 1 1 f 0 00 0 0",
                         g, ram_ce_n[g], ram_oe_n[g], ram_we_n[g], ram_be_n[g], ram_data_oe[g],
                         if_ack[g], mem_ack[g], busy[g], ram_addr[g]);
            end
        end
        rst = 1'b0; mem_init = 1'b0;
    endtask

    task automatic test_if_read();
        int lat, wf, wc, v; logic [31:0] rd;
        run_txn(0, 1'b0, 1'b0, 20'h00010, 4'h0, 32'h0, lat, rd, wf, wc, v);
        n_checks++;
        if (lat !== 3 || rd !== 32'h24020001 || v !== 0) begin
            n_fail++;
            $display("FAIL if_read: lat=%0d rdata=%h viol=%0d, required lat=3 rdata=24020001 viol=0", lat, rd, v);
        end
    endtask

    task automatic test_mem_write_bytes();
        int lat, wf, wc, v; logic [31:0] rd, expv;
        run_txn(0, 1'b1, 1'b1, 20'h00020, 4'b0011, 32'hAABBCCDD, lat, rd, wf, wc, v);
        ref_mem[0][32] = merge(ref_mem[0][32], 32'hAABBCCDD, 4'b0011);
        n_checks++;
        if (lat !== 5 || wf !== 2 || wc !== 2 || v !== 0) begin
            n_fail++;
            $display("FAIL mem_write: lat=%0d we_first=%0d we_cnt=%0d viol=%0d, required 5 2 2 0", lat, wf, wc, v);
        end
        expv = {pat(0, 32)  >> 16, 16'hCCDD};
        run_txn(0, 1'b1, 1'b0, 20'h00020, 4'h0, 32'h0, lat, rd, wf, wc, v);
        n_checks++;
        if (lat !== 3 || rd !== expv || v !== 0) begin
            n_fail++;
            $display("FAIL write_readback: lat=%0d rdata=%h viol=%0d, required lat=3 rdata=%h", lat, rd, v, expv);
        end
    endtask

    task automatic test_simultaneous();
        int mt, it, v;
        mt = -1; it = -1; v = 0;
        @(negedge clk);
        mem_req[0] = 1; mem_we[0] = 0; mem_addr[0] = 20'h00030; if_req[0] = 1; if_addr[0] = 20'h00010;
        for (int k = 1; k <= 30 && it < 0; k++) begin
            @(negedge clk);
            if (mem_ack[0] && if_ack[0]) v++;
            if (ram_data_oe[0] && !ram_oe_n[0]) v++;
            if (mem_ack[0]) begin
                mt = k; mem_req[0] = 0;
                if (mem_rdata[0] !== ref_mem[0][48]) v++;
            end
            if (if_ack[0]) begin
                it = k; if_req[0] = 0;
                if (if_rdata[0] !== ref_mem[0][16]) v++;
            end
        end
        mem_req[0] = 0; if_req[0] = 0;
        n_checks++;
        if (mt !== 3 || it !== 7 || v !== 0) begin
            n_fail++;
            $display("FAIL simultaneous: mem_ack@%0d if_ack@%0d viol=%0d, required 3 7 0", mt, it, v);
        end
    endtask

    task automatic test_reset_mid_write();
        int acks;
        acks = 0;
        @(negedge clk);
        mem_req[0] = 1; mem_we[0] = 1; mem_addr[0] = 20'h000F0; mem_sel[0] = 4'hF; mem_wdata[0] = 32'h12345678;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ram_we_n[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_write_pulse: we_n=%b, required 0", ram_we_n[0]);
        end
        rst = 1'b1; mem_req[0] = 0;
        @(negedge clk);
        n_checks++;
        if (ram_we_n[0] !== 1'b1 || ram_data_oe[0] !== 1'b0 || busy[0] !== 1'b0 || mem_ack[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_write: we_n=%b data_oe=%b busy=%b ack=%b, required 1 0 0 0",
                     ram_we_n[0], ram_data_oe[0], busy[0], mem_ack[0]);
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_ack[0] || if_ack[0]) acks++;
        end
        n_checks++;
        if (acks !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_write_noack: acks=%0d, required 0", acks);
        end
    endtask

    task automatic test_random(input int g, input int n);
        int lat, wf, wc, v, exp_lat; logic [31:0] rd, wd; logic [19:0] addr; logic [3:0] sel; bit is_mem, we;
        for (int i = 0; i < n; i++) begin
            is_mem = 1'($urandom_range(0, 1));
            we     = is_mem && 1'($urandom_range(0, 1));
            addr   = 20'($urandom_range(0, 127));
            sel    = (i == 1) ? 4'h0 : 4'($urandom);
            wd     = $urandom;
            run_txn(g, is_mem, we, addr, sel, wd, lat, rd, wf, wc, v);
            exp_lat = we ? wp_of(g) + 3 : rw_of(g) + 2;
            n_checks++;
            if (lat !== exp_lat || v !== 0) begin
                n_fail++;
                $display("FAIL rand_lat inst%0d #%0d we=%0b: lat=%0d viol=%0d, required lat=%0d viol=0", g, i, we, lat, v, exp_lat);
            end
            n_checks++;
            if (we) begin
                ref_mem[g][addr[7:0]] = merge(ref_mem[g][addr[7:0]], wd, sel);
                if (wf !== 2 || wc !== wp_of(g)) begin
                    n_fail++;
                    $display("FAIL rand_pulse inst%0d #%0d: we_first=%0d we_cnt=%0d, required 2 %0d", g, i, wf, wc, wp_of(g));
                end
            end else if (rd !== ref_mem[g][addr[7:0]] || wc !== 0) begin
                n_fail++;
                $display("FAIL rand_read inst%0d #%0d addr=%h: rdata=%h we_cnt=%0d, required %h 0", g, i, addr, rd, wc, ref_mem[g][addr[7:0]]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_write_bytes();
        test_simultaneous();
        test_reset_mid_write();
        test_random(0, 10);
        test_random(1, 12);
        test_random(2, 12);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
